// File: rtl/rf_access_arbiter.sv
// Two-requester round-robin arbiter in front of a built-in bank of NREG clock-enabled registers.
// All state updates on the falling edge of clk_n; grants are combinational from the owner state.
module rf_access_arbiter #(
  parameter int unsigned NREG      = 8,
  parameter int unsigned AW        = 3,
  parameter int unsigned DW        = 16,
  parameter int unsigned BURST_MAX = 4
) (
  input  logic          clk_n,
  input  logic          rst,
  input  logic          a_req,
  input  logic          a_lock,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic [DW-1:0] a_rdata,
  output logic          a_rvalid,
  input  logic          b_req,
  input  logic          b_lock,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic [DW-1:0] b_rdata,
  output logic          b_rvalid
);

  localparam int unsigned CW = $clog2(BURST_MAX + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_e;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } acc_t;

  generate
    if (NREG != (32'd1 << AW)) begin : g_bad_param
      $error("rf_access_arbiter: NREG must equal 2**AW");
    end
  endgenerate

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ptr_q, ptr_d;   // 0 = A, 1 = B; favoured requester on IDLE contention

  logic [DW-1:0] regs_q [NREG];
  logic [DW-1:0] regs_d [NREG];
  logic [NREG-1:0] wen_c;

  acc_t          acc_c;
  logic          acc_go_c;
  logic [DW-1:0] rd_word_c;

  logic [DW-1:0] a_rdata_q, a_rdata_d;
  logic [DW-1:0] b_rdata_q, b_rdata_d;
  logic          a_rvalid_q, a_rvalid_d;
  logic          b_rvalid_q, b_rvalid_d;

  // State register
  always_ff @(negedge clk_n or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next-state: round-robin entry, bounded lock bursts, forced release to a waiting peer
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (a_req && (!b_req || !ptr_q)) begin
          state_d = OWN_A;
          ptr_d   = 1'b0;
          cnt_d   = '0;
        end else if (b_req) begin
          state_d = OWN_B;
          ptr_d   = 1'b1;
          cnt_d   = '0;
        end
      end
      OWN_A: begin
        if (!a_req) begin
          cnt_d = '0;
          if (b_req) begin
            state_d = OWN_B;
            ptr_d   = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (b_req) begin
          if (a_lock && (cnt_q < CW'(BURST_MAX - 1))) begin
            cnt_d = cnt_q + CW'(1);
          end else begin
            state_d = OWN_B;
            ptr_d   = 1'b1;
            cnt_d   = '0;
          end
        end
      end
      OWN_B: begin
        if (!b_req) begin
          cnt_d = '0;
          if (a_req) begin
            state_d = OWN_A;
            ptr_d   = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else if (a_req) begin
          if (b_lock && (cnt_q < CW'(BURST_MAX - 1))) begin
            cnt_d = cnt_q + CW'(1);
          end else begin
            state_d = OWN_A;
            ptr_d   = 1'b0;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Grant outputs: owner state qualified by the owner's live request
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (state_q == OWN_A) a_gnt = a_req;
    if (state_q == OWN_B) b_gnt = b_req;
  end

  // Access mux, per-register write enables and read capture
  always_comb begin
    acc_c    = '0;
    acc_go_c = a_gnt | b_gnt;
    if (a_gnt) begin
      acc_c = '{we: a_we, addr: a_addr, wdata: a_wdata};
    end else if (b_gnt) begin
      acc_c = '{we: b_we, addr: b_addr, wdata: b_wdata};
    end

    wen_c = '0;
    if (acc_go_c && acc_c.we) wen_c[acc_c.addr] = 1'b1;

    for (int i = 0; i < int'(NREG); i++) begin
      regs_d[i] = wen_c[i] ? acc_c.wdata : regs_q[i];
    end

    rd_word_c  = regs_q[acc_c.addr];
    a_rdata_d  = a_rdata_q;
    b_rdata_d  = b_rdata_q;
    a_rvalid_d = 1'b0;
    b_rvalid_d = 1'b0;
    if (a_gnt && !acc_c.we) begin
      a_rdata_d  = rd_word_c;
      a_rvalid_d = 1'b1;
    end
    if (b_gnt && !acc_c.we) begin
      b_rdata_d  = rd_word_c;
      b_rvalid_d = 1'b1;
    end
  end

  // Register bank and read-return flops
  always_ff @(negedge clk_n or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NREG); i++) regs_q[i] <= '0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
    end else begin
      for (int i = 0; i < int'(NREG); i++) regs_q[i] <= regs_d[i];
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
    end
  end

  assign a_rdata  = a_rdata_q;
  assign b_rdata  = b_rdata_q;
  assign a_rvalid = a_rvalid_q;
  assign b_rvalid = b_rvalid_q;

endmodule

// File: tb/tb_rf_access_arbiter.sv
// Directed bench for rf_access_arbiter: inputs change just after the falling (active) edge,
// outputs are sampled on the rising edge in the middle of each cycle.
module tb_rf_access_arbiter;

  localparam int unsigned NREG      = 8;
  localparam int unsigned AW        = 3;
  localparam int unsigned DW        = 16;
  localparam int unsigned BURST_MAX = 4;

  logic          clk_n = 1'b1;
  logic          rst   = 1'b1;
  logic          a_req, a_lock, a_we;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata;
  logic          a_gnt, a_rvalid;
  logic [DW-1:0] a_rdata;
  logic          b_req, b_lock, b_we;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata;
  logic          b_gnt, b_rvalid;
  logic [DW-1:0] b_rdata;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_reg [NREG];

  rf_access_arbiter #(
    .NREG(NREG), .AW(AW), .DW(DW), .BURST_MAX(BURST_MAX)
  ) dut (
    .clk_n   (clk_n),
    .rst     (rst),
    .a_req   (a_req),
    .a_lock  (a_lock),
    .a_we    (a_we),
    .a_addr  (a_addr),
    .a_wdata (a_wdata),
    .a_gnt   (a_gnt),
    .a_rdata (a_rdata),
    .a_rvalid(a_rvalid),
    .b_req   (b_req),
    .b_lock  (b_lock),
    .b_we    (b_we),
    .b_addr  (b_addr),
    .b_wdata (b_wdata),
    .b_gnt   (b_gnt),
    .b_rdata (b_rdata),
    .b_rvalid(b_rvalid)
  );

  always #5 clk_n = ~clk_n;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic nxt();
    @(negedge clk_n);
    #1;
  endtask

  task automatic smp();
    @(posedge clk_n);
  endtask

  // B reads every register back-to-back starting at 'start'; state must already be OWN_B or
  // the caller accepts that the first cycle is the IDLE cycle handled outside.
  task automatic b_sweep(input int start);
    logic [AW-1:0] cur, prev;
    cur  = '0;
    prev = '0;
    for (int i = 0; i <= int'(NREG); i++) begin
      if (i < int'(NREG)) begin
        cur    = AW'((start + i) % int'(NREG));
        b_req  = 1'b1;
        b_we   = 1'b0;
        b_addr = cur;
      end else begin
        b_req = 1'b0;
      end
      smp();
      if (i < int'(NREG)) chk("sweep_gnt", 32'(b_gnt), 32'd1);
      if (i > 0) begin
        chk("sweep_rvalid", 32'(b_rvalid), 32'd1);
        chk("sweep_rdata", 32'(b_rdata), 32'(exp_reg[prev]));
      end
      prev = cur;
      nxt();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    a_req = 0; a_lock = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_lock = 0; b_we = 0; b_addr = '0; b_wdata = '0;
    for (int i = 0; i < int'(NREG); i++) exp_reg[i] = '0;

    // Reset state, with A requesting while reset is held
    nxt(); nxt();
    a_req = 1;
    smp();
    chk("rst_a_gnt", 32'(a_gnt), 32'd0);
    chk("rst_b_gnt", 32'(b_gnt), 32'd0);
    chk("rst_a_rvalid", 32'(a_rvalid), 32'd0);
    chk("rst_b_rvalid", 32'(b_rvalid), 32'd0);
    chk("rst_a_rdata", 32'(a_rdata), 32'd0);
    chk("rst_b_rdata", 32'(b_rdata), 32'd0);
    nxt();
    a_req = 0;
    rst   = 0;

    // Test 1: A writes addr 2, then reads it back after an idle cycle
    a_req = 1; a_we = 1; a_addr = 3'd2; a_wdata = 16'h1111;
    smp(); chk("t1_wr_gnt0", 32'(a_gnt), 32'd0);
    nxt();
    smp(); chk("t1_wr_gnt1", 32'(a_gnt), 32'd1);
    nxt();
    exp_reg[2] = 16'h1111;
    a_req = 0;
    smp(); chk("t1_drop_gnt", 32'(a_gnt), 32'd0);
    nxt();
    a_req = 1; a_we = 0; a_addr = 3'd2;
    smp(); chk("t1_rd_gnt0", 32'(a_gnt), 32'd0);
    nxt();
    smp(); chk("t1_rd_gnt1", 32'(a_gnt), 32'd1);
    chk("t1_rvalid_pre", 32'(a_rvalid), 32'd0);
    nxt();
    a_req = 0;
    smp();
    chk("t1_rvalid", 32'(a_rvalid), 32'd1);
    chk("t1_rdata", 32'(a_rdata), 32'h1111);
    chk("t1_b_rdata", 32'(b_rdata), 32'd0);
    chk("t1_b_rvalid", 32'(b_rvalid), 32'd0);
    nxt();
    smp();
    chk("t1_rvalid_pulse", 32'(a_rvalid), 32'd0);
    chk("t1_rdata_hold", 32'(a_rdata), 32'h1111);
    nxt();

    // Test 2: contention from IDLE, A first; repeat contention, B first
    a_req = 1; a_we = 0; a_addr = 3'd0;
    b_req = 1; b_we = 0; b_addr = 3'd0;
    smp(); chk("t2_idle_a", 32'(a_gnt), 32'd0); chk("t2_idle_b", 32'(b_gnt), 32'd0);
    nxt();
    smp(); chk("t2_first_a", 32'(a_gnt), 32'd1); chk("t2_first_b", 32'(b_gnt), 32'd0);
    nxt();
    a_req = 0;
    smp(); chk("t2_second_b", 32'(b_gnt), 32'd1); chk("t2_second_a", 32'(a_gnt), 32'd0);
    nxt();
    b_req = 0;
    smp(); chk("t2_drop_b", 32'(b_gnt), 32'd0);
    nxt();
    a_req = 1; b_req = 1;
    smp(); chk("t2_idle2_a", 32'(a_gnt), 32'd0);
    nxt();
    smp(); chk("t2_rep_b", 32'(b_gnt), 32'd1); chk("t2_rep_a", 32'(a_gnt), 32'd0);
    nxt();
    b_req = 0;
    smp(); chk("t2_rep_a2", 32'(a_gnt), 32'd1); chk("t2_rep_b2", 32'(b_gnt), 32'd0);
    nxt();
    a_req = 0;
    nxt();

    // Test 3: A locked burst of 4 writes while B waits, then B, then A again
    a_req = 1; a_lock = 1; a_we = 1; a_addr = 3'd0; a_wdata = 16'h2222;
    smp(); chk("t3_idle", 32'(a_gnt), 32'd0);
    nxt();
    b_req = 1; b_we = 0; b_addr = 3'd0;
    smp(); chk("t3_a_gnt0", 32'(a_gnt), 32'd1); chk("t3_b_wait0", 32'(b_gnt), 32'd0);
    nxt(); exp_reg[0] = 16'h2222;
    a_addr = 3'd1; a_wdata = 16'h4444;
    smp(); chk("t3_a_gnt1", 32'(a_gnt), 32'd1); chk("t3_b_wait1", 32'(b_gnt), 32'd0);
    nxt(); exp_reg[1] = 16'h4444;
    a_addr = 3'd2; a_wdata = 16'h8888;
    smp(); chk("t3_a_gnt2", 32'(a_gnt), 32'd1); chk("t3_b_wait2", 32'(b_gnt), 32'd0);
    nxt(); exp_reg[2] = 16'h8888;
    a_addr = 3'd3; a_wdata = 16'hcccc;
    smp(); chk("t3_a_gnt3", 32'(a_gnt), 32'd1); chk("t3_b_wait3", 32'(b_gnt), 32'd0);
    nxt(); exp_reg[3] = 16'hcccc;
    a_lock = 0; a_we = 0; a_addr = 3'd1;
    smp(); chk("t3_release_a", 32'(a_gnt), 32'd0); chk("t3_release_b", 32'(b_gnt), 32'd1);
    nxt();
    b_req = 0;
    smp();
    chk("t3_regrant_a", 32'(a_gnt), 32'd1);
    chk("t3_b_rvalid", 32'(b_rvalid), 32'd1);
    chk("t3_b_rdata", 32'(b_rdata), 32'h2222);
    nxt();
    a_req = 0;
    smp();
    chk("t3_a_rvalid", 32'(a_rvalid), 32'd1);
    chk("t3_a_rdata", 32'(a_rdata), 32'h4444);
    nxt();

    // Test 4: simultaneous writes to addr 5; A owns first, B's write lands last
    a_req = 1; a_we = 1; a_addr = 3'd5; a_wdata = 16'haaaa;
    b_req = 1; b_we = 1; b_addr = 3'd5; b_wdata = 16'h5555;
    nxt();
    smp(); chk("t4_a_first", 32'(a_gnt), 32'd1); chk("t4_b_wait", 32'(b_gnt), 32'd0);
    nxt();
    a_req = 0;
    smp(); chk("t4_b_second", 32'(b_gnt), 32'd1);
    nxt();
    exp_reg[5] = 16'h5555;
    b_sweep(5);

    // Test 5: reset between edges while B owns with a pending write
    b_req = 1; b_we = 1; b_addr = 3'd4; b_wdata = 16'hffff;
    smp(); chk("t5_idle", 32'(b_gnt), 32'd0);
    nxt();
    smp(); chk("t5_own_b", 32'(b_gnt), 32'd1);
    #1 rst = 1;
    #1;
    chk("t5_gnt_drop", 32'(b_gnt), 32'd0);
    chk("t5_a_rdata_clr", 32'(a_rdata), 32'd0);
    b_req = 0;
    nxt();
    rst = 0;
    for (int i = 0; i < int'(NREG); i++) exp_reg[i] = '0;
    a_req = 1; a_we = 0; a_addr = 3'd4;
    smp(); chk("t5_back_idle", 32'(a_gnt), 32'd0);
    nxt();
    smp(); chk("t5_rd_gnt", 32'(a_gnt), 32'd1);
    nxt();
    a_req = 0;
    smp();
    chk("t5_rvalid", 32'(a_rvalid), 32'd1);
    chk("t5_rdata", 32'(a_rdata), 32'd0);
    nxt();

    // Test 6: A writes every address with idle gaps, B reads all back
    for (int i = 0; i < int'(NREG); i++) begin
      a_req = 1; a_we = 1; a_addr = AW'(i); a_wdata = 16'hcccc;
      smp(); chk("t6_idle_gap", 32'(a_gnt), 32'd0);
      nxt();
      smp(); chk("t6_wr_gnt", 32'(a_gnt), 32'd1);
      nxt();
      exp_reg[i] = 16'hcccc;
      a_req = 0;
      smp(); chk("t6_drop", 32'(a_gnt), 32'd0);
      nxt();
    end
    b_req = 1; b_we = 0; b_addr = 3'd0;
    smp(); chk("t6_b_idle", 32'(b_gnt), 32'd0);
    nxt();
    b_sweep(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
